// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// master drives valid/data/last, slave returns ready.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into little-endian words, writes them to
// IMEM from address 0 and holds the cpu in reset until the load finishes.
// Ports: clk, reset_n (async, active-low), bs (byte stream, slave),
//   reload (restart from DONE), imem_we/imem_addr/imem_wdata (IMEM write),
//   cpu_reset (high while loading), load_done, err_ovf (sticky overflow).
module imem_loader #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 32,
    parameter int BYTES  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    imem_loader_if.slave      bs,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              err_ovf
);
    localparam int BC_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        COLLECT,
        WRITE,
        OVERFLOW,
        DONE
    } state_t;

    state_t            state;
    logic [BC_W-1:0]   byte_cnt;
    logic [ADDR_W-1:0] word_addr;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] word_nxt;
    logic              last_q;
    logic              accept;
    logic              closing;

    assign accept  = bs.in_valid & bs.in_ready;
    assign closing = bs.in_last | (byte_cnt == BC_W'(BYTES - 1));

    // shift_q is cleared after every word, so unfilled upper bytes stay zero.
    always_comb begin
        word_nxt = shift_q;
        word_nxt[{byte_cnt, 3'b000} +: 8] = bs.in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= COLLECT;
            byte_cnt    <= '0;
            word_addr   <= '0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            bs.in_ready <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cpu_reset   <= 1'b1;
            load_done   <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    bs.in_ready <= 1'b1;
                    if (accept) begin
                        if (closing) begin
                            imem_we     <= 1'b1;
                            imem_addr   <= word_addr;
                            imem_wdata  <= word_nxt;
                            shift_q     <= '0;
                            byte_cnt    <= '0;
                            last_q      <= bs.in_last;
                            bs.in_ready <= 1'b0;
                            state       <= WRITE;
                        end else begin
                            shift_q  <= word_nxt;
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                WRITE: begin
                    imem_we   <= 1'b0;
                    word_addr <= word_addr + ADDR_W'(1);
                    if (last_q) begin
                        cpu_reset <= 1'b0;
                        load_done <= 1'b1;
                        state     <= DONE;
                    end else if (word_addr == '1) begin
                        // IMEM full and more program to come
                        err_ovf     <= 1'b1;
                        bs.in_ready <= 1'b1;
                        state       <= OVERFLOW;
                    end else begin
                        bs.in_ready <= 1'b1;
                        state       <= COLLECT;
                    end
                end
                OVERFLOW: begin
                    bs.in_ready <= 1'b1;
                    if (accept && bs.in_last) begin
                        bs.in_ready <= 1'b0;
                        cpu_reset   <= 1'b0;
                        load_done   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    bs.in_ready <= 1'b0;
                    if (reload) begin
                        word_addr   <= '0;
                        byte_cnt    <= '0;
                        shift_q     <= '0;
                        last_q      <= 1'b0;
                        cpu_reset   <= 1'b1;
                        load_done   <= 1'b0;
                        err_ovf     <= 1'b0;
                        bs.in_ready <= 1'b1;
                        state       <= COLLECT;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte packing, write timing,
// overflow, mid-load reset and reload.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        err_ovf;

    imem_loader_if bif ();

    imem_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bs         (bif.slave),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // write log filled from the IMEM port
    int          wr_total = 0;
    logic [3:0]  wr_addr [64];
    logic [31:0] mem [16];

    always @(negedge clk) begin
        if (reset_n && imem_we) begin
            check("wr_rdy", 32'(bif.in_ready), 32'd0);
            if (wr_total < 64) wr_addr[wr_total] = imem_addr;
            mem[imem_addr] = imem_wdata;
            wr_total++;
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        bif.in_last  = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (bif.in_ready) break;
            n++;
            if (n > 40) begin
                check("send_to", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic do_reset();
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
        bif.in_data  = 8'h00;
        reload       = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [7:0] t2b [6];
    int         base;

    initial begin
        t2b[0] = 8'hAA; t2b[1] = 8'hBB; t2b[2] = 8'hCC;
        t2b[3] = 8'hDD; t2b[4] = 8'hEE; t2b[5] = 8'hFF;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
        bif.in_data  = 8'h00;

        // reset values
        @(negedge clk);
        check("rst_rdy",  32'(bif.in_ready), 32'd0);
        check("rst_we",   32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wd",   imem_wdata, 32'd0);
        check("rst_cpu",  32'(cpu_reset), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_ovf",  32'(err_ovf), 32'd0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_rise", 32'(bif.in_ready), 32'd1);

        // T1: single word, write timing
        base = wr_total;
        send(8'h13, 1'b0);
        send(8'h05, 1'b0);
        send(8'h10, 1'b0);
        send(8'h00, 1'b1);
        check("t1_we",   32'(imem_we), 32'd1);
        check("t1_addr", 32'(imem_addr), 32'd0);
        check("t1_wd",   imem_wdata, 32'h00100513);
        check("t1_cpuN", 32'(cpu_reset), 32'd1);
        @(posedge clk);
        #1;
        check("t1_cpu",  32'(cpu_reset), 32'd0);
        check("t1_done", 32'(load_done), 32'd1);
        check("t1_rdy",  32'(bif.in_ready), 32'd0);
        check("t1_we0",  32'(imem_we), 32'd0);
        settle();
        check("t1_nwr",  32'(wr_total - base), 32'd1);

        // T2: back-to-back, partial last word; stray reload ignored
        do_reset();
        base = wr_total;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                reload = 1'b1;
                @(posedge clk);
                #1 reload = 1'b0;
            end
            send(t2b[i], i == 5);
        end
        settle();
        check("t2_nwr", 32'(wr_total - base), 32'd2);
        check("t2_m0",  mem[0], 32'hDDCCBBAA);
        check("t2_m1",  mem[1], 32'h0000FFEE);
        check("t2_done", 32'(load_done), 32'd1);

        // T3: random gaps, in_last pulsed with in_valid low
        do_reset();
        mem[0] = '0;
        mem[1] = '0;
        base = wr_total;
        for (int i = 0; i < 6; i++) begin
            bif.in_last = 1'b1;
            bif.in_data = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(t2b[i], i == 5);
        end
        settle();
        check("t3_nwr", 32'(wr_total - base), 32'd2);
        check("t3_m0",  mem[0], 32'hDDCCBBAA);
        check("t3_m1",  mem[1], 32'h0000FFEE);

        // T4: 17 words into a 16-word memory
        do_reset();
        base = wr_total;
        for (int i = 0; i < 68; i++) begin
            send(8'(i), i == 67);
            if (i == 63) begin
                settle();
                check("t4_ovf_mid", 32'(err_ovf), 32'd1);
                check("t4_cpu_mid", 32'(cpu_reset), 32'd1);
            end
        end
        settle();
        check("t4_nwr", 32'(wr_total - base), 32'd16);
        for (int k = 0; k < 16; k++)
            check("t4_addr", 32'(wr_addr[base + k]), 32'(k));
        check("t4_m0",   mem[0], 32'h03020100);
        check("t4_m15",  mem[15], 32'h3F3E3D3C);
        check("t4_ovf",  32'(err_ovf), 32'd1);
        check("t4_done", 32'(load_done), 32'd1);
        check("t4_cpu",  32'(cpu_reset), 32'd0);

        // T6: reload from DONE
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        check("t6_cpu",  32'(cpu_reset), 32'd1);
        check("t6_done", 32'(load_done), 32'd0);
        check("t6_ovf",  32'(err_ovf), 32'd0);
        check("t6_rdy",  32'(bif.in_ready), 32'd1);
        base = wr_total;
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        send(8'hBE, 1'b0);
        send(8'hEF, 1'b1);
        settle();
        check("t6_nwr",  32'(wr_total - base), 32'd1);
        check("t6_addr", 32'(wr_addr[base]), 32'd0);
        check("t6_m0",   mem[0], 32'hEFBEADDE);
        check("t6_done2", 32'(load_done), 32'd1);

        // T5: async reset mid-load
        do_reset();
        base = wr_total;
        send(8'h99, 1'b0);
        check("t5_cpu0", 32'(cpu_reset), 32'd1);
        send(8'h88, 1'b0);
        check("t5_cpu1", 32'(cpu_reset), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_rcpu", 32'(cpu_reset), 32'd1);
        check("t5_rrdy", 32'(bif.in_ready), 32'd0);
        #1 reset_n = 1'b1;
        send(8'h11, 1'b0);
        check("t5_cpu2", 32'(cpu_reset), 32'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        check("t5_cpu3", 32'(cpu_reset), 32'd1);
        settle();
        check("t5_nwr",  32'(wr_total - base), 32'd1);
        check("t5_addr", 32'(wr_addr[base]), 32'd0);
        check("t5_m0",   mem[0], 32'h44332211);
        check("t5_done", 32'(load_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
